// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer for an external 8-bit divider.
// Collects two hex operands, launches the divider, shows quotient or
// remainder, and flags divide-by-zero or a divider that never answers.
module calc_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_27mhz,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        btn_div,
  input  logic        btn_quot,
  input  logic        btn_rem,
  input  logic        btn_clear,
  output logic        div_start,
  output logic [7:0]  dividend,
  output logic [7:0]  divisor,
  input  logic        div_done,
  input  logic [7:0]  quotient,
  input  logic [7:0]  remainder,
  output logic [15:0] disp_value,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    op_a_r, op_a_s;
  logic [7:0]    op_b_r, op_b_s;
  logic [7:0]    quot_r, quot_s;
  logic [7:0]    rem_r, rem_s;
  logic          sel_r, sel_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          any_btn_s;
  logic [15:0]   disp_s;

  // Next-state and next-register values; btn_clear overrides everything.
  always_comb begin
    state_s   = state_r;
    op_a_s    = op_a_r;
    op_b_s    = op_b_r;
    quot_s    = quot_r;
    rem_s     = rem_r;
    sel_s     = sel_r;
    cnt_s     = cnt_r;
    any_btn_s = btn_div | btn_quot | btn_rem;
    if (btn_clear) begin
      state_s = ENTER_A;
      op_a_s  = 8'h00;
      op_b_s  = 8'h00;
      quot_s  = 8'h00;
      rem_s   = 8'h00;
      sel_s   = 1'b0;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ENTER_A: begin
          // A button in the same cycle as a key wins and the key is dropped.
          if (btn_div) begin
            state_s = ENTER_B;
            op_b_s  = 8'h00;
          end else if (any_btn_s) begin
            state_s = ENTER_A;
          end else if (key_valid) begin
            op_a_s = {op_a_r[3:0], key_code};
          end else begin
            op_a_s = op_a_r;
          end
        end
        ENTER_B: begin
          if (btn_quot || btn_rem) begin
            sel_s   = ~btn_quot;
            cnt_s   = '0;
            state_s = (op_b_r == 8'h00) ? ERROR : START;
          end else if (any_btn_s) begin
            state_s = ENTER_B;
          end else if (key_valid) begin
            op_b_s = {op_b_r[3:0], key_code};
          end else begin
            op_b_s = op_b_r;
          end
        end
        START: begin
          state_s = WAIT;
          cnt_s   = '0;
        end
        WAIT: begin
          // A done on the final timeout cycle still counts as success.
          if (div_done) begin
            quot_s  = quotient;
            rem_s   = remainder;
            state_s = SHOW;
          end else if (cnt_r == CNT_LAST) begin
            state_s = ERROR;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        SHOW: begin
          if (btn_quot) begin
            sel_s = 1'b0;
          end else if (btn_rem) begin
            sel_s = 1'b1;
          end else if (key_valid) begin
            op_a_s  = {4'h0, key_code};
            op_b_s  = 8'h00;
            state_s = ENTER_A;
          end else begin
            state_s = SHOW;
          end
        end
        ERROR: begin
          state_s = ERROR;
        end
        default: begin
          state_s = ENTER_A;
        end
      endcase
    end
  end

  // Display image for the upcoming state, registered below.
  always_comb begin
    disp_s = 16'h0000;
    case (state_s)
      ENTER_A:             disp_s = {8'h00, op_a_s};
      ENTER_B, START, WAIT: disp_s = {op_a_s, op_b_s};
      SHOW:                disp_s = {8'h00, (sel_s ? rem_s : quot_s)};
      ERROR:               disp_s = 16'hEEEE;
      default:             disp_s = 16'h0000;
    endcase
  end

  // State, operand/result registers and registered outputs.
  always_ff @(posedge clk_27mhz) begin
    if (rst) begin
      state_r    <= ENTER_A;
      op_a_r     <= 8'h00;
      op_b_r     <= 8'h00;
      quot_r     <= 8'h00;
      rem_r      <= 8'h00;
      sel_r      <= 1'b0;
      cnt_r      <= '0;
      div_start  <= 1'b0;
      dividend   <= 8'h00;
      divisor    <= 8'h00;
      disp_value <= 16'h0000;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      op_a_r     <= op_a_s;
      op_b_r     <= op_b_s;
      quot_r     <= quot_s;
      rem_r      <= rem_s;
      sel_r      <= sel_s;
      cnt_r      <= cnt_s;
      div_start  <= (state_s == START);
      dividend   <= op_a_s;
      divisor    <= op_b_s;
      disp_value <= disp_s;
      busy       <= (state_s == START) || (state_s == WAIT);
      err        <= (state_s == ERROR);
    end
  end

endmodule
